// File: rtl/output_writeback_if.sv
// Result-stream and memory write-port bundle for output_writeback.
// The slave side is the write-back block; the master side drives results and mem_ready.
interface output_writeback_if #(
  parameter int DW = 32,
  parameter int XW = 7,
  parameter int YW = 7,
  parameter int CW = 4,
  parameter int AW = 20
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [CW-1:0] in_ch;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid;
  logic          mem_ready;

  modport master (
    output in_data, in_valid, in_x, in_y, in_ch, mem_ready,
    input  mem_addr, mem_wdata, mem_valid
  );

  modport slave (
    input  in_data, in_valid, in_x, in_y, in_ch, mem_ready,
    output mem_addr, mem_wdata, mem_valid
  );
endinterface

// File: rtl/output_writeback.sv
// Buffers top_system results in a small FIFO and writes them to external memory,
// pulsing done once every pixel of the layer has been accepted and written.
//
// state | meaning
// IDLE  | waiting for start; in_valid ignored
// RUN   | accepting results until TOTAL have arrived
// DRAIN | input ignored; emptying the FIFO to memory
// DONE  | one-cycle done pulse, then back to IDLE
module output_writeback #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int BASE_ADDR          = 0,
  parameter int FIFO_DEPTH         = 4,
  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int CNTW  = $clog2(TOTAL + 1)
) (
  input  logic                clk,
  input  logic                arst_n_in,
  input  logic                start,
  output_writeback_if.slave   wb,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNTW-1:0]     write_count
);
  localparam int AW = $clog2(EXT_MEM_HEIGHT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNTW-1:0] TOTAL_C = CNTW'(TOTAL);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [CNTW-1:0]         r_acc_cnt;
  logic [CNTW-1:0]         r_write_count;
  logic                    r_overflow;
  logic [PW:0]             r_wr_ptr;
  logic [PW:0]             r_rd_ptr;
  logic [AW-1:0]           r_addr_mem [FIFO_DEPTH];
  logic [ACCUMULATION_WIDTH-1:0] r_data_mem [FIFO_DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_flush;
  logic            w_accept;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [CNTW-1:0] w_acc_next;
  logic [31:0]     w_addr32;
  logic [AW-1:0]   w_addr;

  assign w_addr32 = 32'(BASE_ADDR)
                  + (32'(wb.in_ch) * 32'(FEATURE_MAP_HEIGHT) + 32'(wb.in_y))
                    * 32'(FEATURE_MAP_WIDTH)
                  + 32'(wb.in_x);
  assign w_addr   = w_addr32[AW-1:0];

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                      (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_flush    = (r_state == S_IDLE) && start;
  assign w_accept   = (r_state == S_RUN) && wb.in_valid;
  assign w_pop      = !w_empty && wb.mem_ready;
  // a full FIFO still takes the new word when the head leaves in the same cycle
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_drop     = w_accept && w_full && !w_pop;
  assign w_acc_next = r_acc_cnt + 1'b1;

  assign wb.mem_valid = !w_empty;
  assign wb.mem_addr  = r_addr_mem[r_rd_ptr[PW-1:0]];
  assign wb.mem_wdata = r_data_mem[r_rd_ptr[PW-1:0]];
  assign busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign overflow     = r_overflow;
  assign write_count  = r_write_count;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_addr_mem[i] <= '0;
        r_data_mem[i] <= '0;
      end
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_addr_mem[r_wr_ptr[PW-1:0]] <= w_addr;
        r_data_mem[r_wr_ptr[PW-1:0]] <= wb.in_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state       <= S_IDLE;
      r_acc_cnt     <= '0;
      r_write_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_flush) begin
        r_write_count <= '0;
      end else if (w_pop && (r_write_count != TOTAL_C)) begin
        r_write_count <= r_write_count + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RUN;
            r_acc_cnt  <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= w_acc_next;
            if (w_acc_next == TOTAL_C) begin
              r_state <= S_DRAIN;
            end
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
